// File: rtl/calc_pkg.sv
// Shared constants for the 4-bit calculator: entry-stage encoding, operand/opcode widths, opcode decode values.
package calc_pkg;

  localparam int OPND_W = 4;
  localparam int OPC_W  = 3;

  localparam logic [1:0] GET_A  = 2'd0;
  localparam logic [1:0] GET_B  = 2'd1;
  localparam logic [1:0] GET_OP = 2'd2;
  localparam logic [1:0] ISSUE  = 2'd3;

  typedef enum logic [1:0] {
    ST_GET_A  = GET_A,
    ST_GET_B  = GET_B,
    ST_GET_OP = GET_OP,
    ST_ISSUE  = ISSUE
  } stage_e;

  // ABS_A/ABS_B ignore bit 0; the values below are the bit-0-clear forms
  localparam logic [OPC_W-1:0] OPC_ADD     = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ADD_ALT = 3'b100;
  localparam logic [OPC_W-1:0] OPC_A_SUB_B = 3'b001;
  localparam logic [OPC_W-1:0] OPC_B_SUB_A = 3'b101;
  localparam logic [OPC_W-1:0] OPC_ABS_A   = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ABS_B   = 3'b010;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop sync, stability counter, one-cycle pulse on debounced press.
// Latency raw press -> press pulse = 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Carried in pressed-high polarity so the all-zero reset state means released
  logic             sync1, sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_entry_sequencer.sv
// Sequential A/B/opcode entry from switches, issued to the calculator on valid/ready; op_valid held until accepted.
// Press pulse -> register update 1 cycle. CALC_ENTRY_REISSUE_EN adds KEY[2] repeat-last-operation.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [2:0]        KEY,
  input  logic [7:0]        SW,
  output logic [OPND_W-1:0] A,
  output logic [OPND_W-1:0] B,
  output logic [OPC_W-1:0]  OP,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        stage
);

  logic enter_p, clear_p, reissue_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY[0]),
    .press (enter_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY[1]),
    .press (clear_p)
  );

`ifdef CALC_ENTRY_REISSUE_EN
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reissue (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY[2]),
    .press (reissue_p)
  );
`else
  logic unused_reissue_key;
  assign unused_reissue_key = KEY[2];
  assign reissue_p          = 1'b0;
`endif

  stage_e            state_q, state_n;
  logic [OPND_W-1:0] a_q, a_n, b_q, b_n;
  logic [OPC_W-1:0]  op_q, op_n;
  logic              vld_q, vld_n;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      vld_q   <= vld_n;
    end
  end

  // Clear has priority over enter; ISSUE ignores both so a valid is never withdrawn
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    vld_n   = vld_q;
    case (state_q)
      ST_GET_A: begin
        if (clear_p) begin
          state_n = ST_GET_A;
        end else if (enter_p) begin
          a_n     = SW[7:4];
          state_n = ST_GET_B;
        end else if (reissue_p) begin
          vld_n   = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_GET_B: begin
        if (clear_p) begin
          state_n = ST_GET_A;
        end else if (enter_p) begin
          b_n     = SW[3:0];
          state_n = ST_GET_OP;
        end
      end
      ST_GET_OP: begin
        if (clear_p) begin
          state_n = ST_GET_A;
        end else if (enter_p) begin
          op_n    = SW[2:0];
          vld_n   = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (vld_q && op_ready) begin
          vld_n   = 1'b0;
          state_n = ST_GET_A;
        end
      end
      default: state_n = ST_GET_A;
    endcase
  end

  assign A        = a_q;
  assign B        = b_q;
  assign OP       = op_q;
  assign op_valid = vld_q;
  assign stage    = state_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Self-checking bench for calc_entry_sequencer with DEBOUNCE_CYCLES=4; accepted operations are scored against a queue.
module tb_calc_entry_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [2:0] KEY;
  logic [7:0] SW;
  logic [3:0] A, B;
  logic [2:0] OP;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] stage;

  always #5 CLOCK_50 = ~CLOCK_50;

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .KEY      (KEY),
    .SW       (SW),
    .A        (A),
    .B        (B),
    .OP       (OP),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .stage    (stage)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          vld_cycles = 0;
  int          vld_base;
  logic [10:0] sb_q[$];
  logic [10:0] sb_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [2:0] mask);
    KEY = ~mask;
    step(8);
    KEY = 3'b111;
    step(8);
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLOCK_50);
      if (RESET_N && op_valid) vld_cycles++;
      if (RESET_N && op_valid && op_ready) begin
        check_eq("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check_eq("sb_result", {A, B, OP}, sb_exp);
        end
      end
    end
  endtask

  task automatic run_test();
    RESET_N  = 1'b0;
    KEY      = 3'b111;
    SW       = 8'h00;
    op_ready = 1'b0;
    step(3);
    check_eq("rst_A", A, 0);
    check_eq("rst_B", B, 0);
    check_eq("rst_OP", OP, 0);
    check_eq("rst_vld", op_valid, 0);
    check_eq("rst_stage", stage, 0);
    RESET_N = 1'b1;
    step(2);

    // First enter with latency check: pulse after 6 edges, state after 7
    SW     = 8'h5A;
    KEY[0] = 1'b0;
    step(6);
    check_eq("lat_pre_stage", stage, 0);
    step(1);
    check_eq("lat_stage", stage, 1);
    check_eq("cap_A", A, 4'h5);
    step(1);
    KEY[0] = 1'b1;
    step(8);

    SW = 8'h5A;
    press(3'b001);
    check_eq("cap_B_stage", stage, 2);
    check_eq("cap_B", B, 4'hA);
    SW = 8'h05;
    sb_q.push_back({4'h5, 4'hA, 3'b101});
    press(3'b001);
    check_eq("cap_OP", OP, 3'b101);
    check_eq("issue_vld", op_valid, 1);
    check_eq("issue_stage", stage, 3);

    // Enter and clear in ISSUE are both ignored
    SW = 8'hFF;
    press(3'b001);
    check_eq("issue_enter_stage", stage, 3);
    check_eq("issue_enter_regs", {A, B, OP}, {4'h5, 4'hA, 3'b101});
    press(3'b010);
    check_eq("issue_clear_vld", op_valid, 1);
    check_eq("issue_clear_stage", stage, 3);

    op_ready = 1'b1;
    check_eq("accept_cycle_vld", op_valid, 1);
    step(1);
    op_ready = 1'b0;
    check_eq("post_accept_vld", op_valid, 0);
    check_eq("post_accept_stage", stage, 0);
    check_eq("post_accept_regs", {A, B, OP}, {4'h5, 4'hA, 3'b101});

    // Bouncing enter gives exactly one pulse once stable
    SW = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      KEY[0] = 1'b0;
      step(2);
      KEY[0] = 1'b1;
      step(2);
    end
    KEY[0] = 1'b0;
    step(5);
    check_eq("bounce_early_stage", stage, 0);
    step(10);
    check_eq("bounce_stage", stage, 1);
    check_eq("bounce_A", A, 4'h3);
    KEY[0] = 1'b1;
    step(10);
    check_eq("bounce_single", stage, 1);

    // Clear and enter together in GET_B: clear wins
    SW = 8'h77;
    press(3'b011);
    check_eq("clr_enter_stage", stage, 0);
    check_eq("clr_enter_B", B, 4'hA);

    // Clear in GET_OP keeps captured values
    SW = 8'h91;
    press(3'b001);
    press(3'b001);
    check_eq("pre_clr_stage", stage, 2);
    press(3'b010);
    check_eq("clr_op_stage", stage, 0);
    check_eq("clr_op_regs", {A, B, OP}, {4'h9, 4'h1, 3'b101});

    // Async reset in the middle of ISSUE
    SW = 8'hC0;
    press(3'b001);
    SW = 8'h0E;
    press(3'b001);
    SW = 8'h07;
    press(3'b001);
    check_eq("rst_mid_pre_vld", op_valid, 1);
    #3;
    RESET_N = 1'b0;
    #1;
    check_eq("rst_mid_vld", op_valid, 0);
    check_eq("rst_mid_regs", {A, B, OP}, 0);
    check_eq("rst_mid_stage", stage, 0);
    #9;
    RESET_N = 1'b1;
    step(2);

    // op_ready tied high: valid for exactly one cycle
    op_ready = 1'b1;
    SW = 8'hB0;
    press(3'b001);
    SW = 8'h04;
    press(3'b001);
    SW = 8'h01;
    sb_q.push_back({4'hB, 4'h4, 3'b001});
    vld_base = vld_cycles;
    press(3'b001);
    check_eq("tied_vld_cycles", vld_cycles - vld_base, 1);
    check_eq("tied_stage", stage, 0);
    check_eq("tied_vld", op_valid, 0);
    op_ready = 1'b0;

    vld_base = vld_cycles;
`ifdef CALC_ENTRY_REISSUE_EN
    sb_q.push_back({4'hB, 4'h4, 3'b001});
    press(3'b100);
    check_eq("reissue_vld", op_valid, 1);
    check_eq("reissue_stage", stage, 3);
    check_eq("reissue_regs", {A, B, OP}, {4'hB, 4'h4, 3'b001});
    op_ready = 1'b1;
    step(1);
    op_ready = 1'b0;
    check_eq("reissue_done_vld", op_valid, 0);
    check_eq("reissue_done_stage", stage, 0);
`else
    press(3'b100);
    check_eq("reissue_off_vld", op_valid, 0);
    check_eq("reissue_off_stage", stage, 0);
    check_eq("reissue_off_cycles", vld_cycles - vld_base, 0);
    check_eq("reissue_off_regs", {A, B, OP}, {4'hB, 4'h4, 3'b001});
`endif

    check_eq("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      run_test();
      begin
        #200000;
        check_eq("timeout", 1, 0);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_sequencer.md
Name: calc_entry_sequencer

Overview:
Front-end initiator for the 4-bit calculator datapath. The calculator core consumes operands A/B and a 3-bit opcode. This block builds those from the same board switches using pushbutton-driven sequential entry. It debounces and edge-detects the KEY buttons, steps through operand A, operand B and opcode capture, then issues one operation to the calculator core over a valid/ready handshake.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable synchronized samples before a key level is accepted (minimum 2).
CNT_W, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
CLOCK_50  input  1  system clock, all state on rising edge.
RESET_N  input  1  asynchronous active-low reset.
KEY  input  3  raw pushbuttons, active-low (0 = pressed). KEY[0] = enter, KEY[1] = clear, KEY[2] = reissue (see optional feature).
SW  input  8  data switches, sampled on enter.
A  output  4  captured operand A, registered.
B  output  4  captured operand B, registered.
OP  output  3  captured opcode, registered; same encoding as the calculator opcode decode.
op_valid  output  1  operation available.
op_ready  input  1  calculator accepts the operation.
stage  output  2  current FSM state, for LED/HEX echo: 0 GET_A, 1 GET_B, 2 GET_OP, 3 ISSUE.

Behaviour:
- Reset (RESET_N low, async): A=0, B=0, OP=0, op_valid=0, stage=GET_A (0). Debounced levels = released. Synchronizers and counters = 0.
- Per key:
  - 2-flop synchronizer.
  - Debounce counter resets on any mismatch between the synchronized sample and the debounced level.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  - press pulse: one cycle, on the debounced released->pressed transition only. Release generates nothing. A held key generates exactly one pulse.
- Latency: raw press to press pulse = 2 + DEBOUNCE_CYCLES cycles. Press pulse to state/register update = 1 cycle.
- FSM:
  - GET_A: enter -> A<=SW[7:4], go GET_B.
  - GET_B: enter -> B<=SW[3:0], go GET_OP.
  - GET_OP: enter -> OP<=SW[2:0], op_valid<=1, go ISSUE.
  - ISSUE: op_valid=1. A, B, OP are held stable. On a cycle with op_valid & op_ready, op_valid<=0 and go GET_A next cycle.
- Clear (KEY[1] press) in GET_A/GET_B/GET_OP: go GET_A. A, B, OP are retained (not zeroed).
- Clear in ISSUE: ignored. A valid is never withdrawn before acceptance.
- Enter in ISSUE: ignored and not queued.
- Simultaneous enter and clear pulses in the same cycle: clear wins.
- op_ready while op_valid=0: no effect.
- op_ready tied high: acceptance occurs in the first ISSUE cycle, so op_valid is high exactly one cycle.
- Reset asserted mid-ISSUE: op_valid drops immediately (async). No partial handshake survives.
- A, B and OP only change on their own capture event (and at reset).

Optional Feature:
Macro CALC_ENTRY_REISSUE_EN.
- Defined: a KEY[2] press while in GET_A sets op_valid<=1 with the current A/B/OP and goes to ISSUE. This repeats the last operation without re-entry. Priority in GET_A: clear > enter > reissue.
- Not defined: the KEY[2] synchronizer, debouncer and pulse logic are not instantiated, and KEY[2] is ignored.

Decomposition:
- Shared package calc_pkg holds:
  - the stage encoding localparams (GET_A=2'd0, GET_B=2'd1, GET_OP=2'd2, ISSUE=2'd3);
  - opcode width (3) and operand width (4) constants;
  - the opcode encodings shared with the calculator decode: ADD=3'b000/3'b100, A_SUB_B=3'b001, B_SUB_A=3'b101, ABS_A=3'b11x, ABS_B=3'b01x.
- One sub-module is natural: key_debounce (synchronizer + counter + press pulse, parameterized by DEBOUNCE_CYCLES/CNT_W). It is instantiated per key: 2 instances, or 3 with CALC_ENTRY_REISSUE_EN.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then press/release enter three times with SW=8'h5A, then 8'h5A, then 8'h05, op_ready=0 -> A=4'h5, B=4'hA, OP=3'b101, op_valid=1, stage=3. Each press pulse appears 6 cycles after the KEY[0] low edge.
- Hold in ISSUE 10 cycles, then op_ready=1 for one cycle -> op_valid is high through the accept cycle and low after. stage=0 next cycle. A/B/OP unchanged.
- Bounce KEY[0] low/high every 2 cycles for 12 cycles, then hold low -> exactly one enter pulse, and only after 4 stable samples. Stage advances by exactly 1.
- Enter A, then press clear and enter in the same cycle while in GET_B -> stage=0 and B unchanged. Clear press in ISSUE -> op_valid stays 1.
- Assert RESET_N low for 1 cycle mid-ISSUE, asynchronously to the clock -> op_valid=0, A=B=OP=0 and stage=0 immediately.
- With CALC_ENTRY_REISSUE_EN: complete one operation, then press KEY[2] in GET_A -> op_valid=1 with the identical A/B/OP. Without the macro, the same stimulus -> no change.
